// File: rtl/serializer_nbyte.sv
// Width-down converter: 1/2/4/8-lane words in, one OUT_W lane per cycle out, MSB lane first.
// Valid/ready on both sides; a one-word pending slot keeps back-to-back words bubble-free.
module serializer_nbyte #(
   parameter int unsigned OUT_W     = 8,
   parameter int unsigned MAX_LANES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enb,
   input  logic [OUT_W*MAX_LANES-1:0] dataIn,
   input  logic [1:0]                 dataS,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [OUT_W-1:0]           dataOut,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_last,
   output logic                       busy
);

   localparam int unsigned IN_W  = OUT_W * MAX_LANES;
   localparam int unsigned CNT_W = $clog2(MAX_LANES + 1);

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

   state_t                 state_q, state_d;
   logic [IN_W-1:0]        shift_q, shift_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IN_W-1:0]        pend_q, pend_d;
   logic [CNT_W-1:0]       pend_lanes_q, pend_lanes_d;
   logic                   pend_full_q, pend_full_d;
   logic [OUT_W-1:0]       data_out_q, data_out_d;
   logic                   out_valid_q, out_valid_d;
   logic                   out_last_q, out_last_d;
   logic                   busy_q, busy_d;

   logic                   accept;
   logic                   xfer;
   logic                   load_ev;
   logic                   do_load;
   logic [IN_W-1:0]        load_w;
   logic [CNT_W-1:0]       load_l;
   logic [IN_W-1:0]        aligned;

   // Lane count for a size code, clamped to what the datapath can hold.
   function automatic logic [CNT_W-1:0] lanes_of(input logic [1:0] code);
      int unsigned l;
      l = 32'd1 << code;
      if (l > MAX_LANES) l = MAX_LANES;
      return CNT_W'(l);
   endfunction

   // Move the first lane to the top of the shifter; unused upper bits fall off.
   function automatic logic [IN_W-1:0] align(input logic [IN_W-1:0] w,
                                             input logic [CNT_W-1:0] l);
      return w << (OUT_W * (MAX_LANES - 32'(l)));
   endfunction

   assign in_ready  = enb && !rst && !pend_full_q;
   assign dataOut   = data_out_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      pend_d       = pend_q;
      pend_lanes_d = pend_lanes_q;
      pend_full_d  = pend_full_q;
      data_out_d   = data_out_q;
      do_load      = 1'b0;
      load_w       = '0;
      load_l       = '0;
      aligned      = '0;

      accept  = in_valid && in_ready;
      xfer    = enb && out_valid_q && out_ready;
      load_ev = enb && ((state_q == ST_IDLE) || (xfer && (cnt_q == CNT_W'(1))));

      // Shifter reload: pending slot has priority over a fresh input.
      if (load_ev) begin
         if (pend_full_q) begin
            do_load     = 1'b1;
            load_w      = pend_q;
            load_l      = pend_lanes_q;
            pend_full_d = 1'b0;
         end else if (accept) begin
            do_load = 1'b1;
            load_w  = dataIn;
            load_l  = lanes_of(dataS);
         end
      end

      // Any accepted word not going straight into the shifter parks in the slot.
      if (accept && !(load_ev && !pend_full_q)) begin
         pend_d       = dataIn;
         pend_lanes_d = lanes_of(dataS);
         pend_full_d  = 1'b1;
      end

      if (do_load) begin
         aligned    = align(load_w, load_l);
         data_out_d = aligned[IN_W-1 -: OUT_W];
         shift_d    = aligned << OUT_W;
         cnt_d      = load_l;
         state_d    = ST_SHIFT;
      end else if (load_ev) begin
         cnt_d   = '0;
         state_d = ST_IDLE;
      end else if (xfer) begin
         data_out_d = shift_q[IN_W-1 -: OUT_W];
         shift_d    = shift_q << OUT_W;
         cnt_d      = cnt_q - CNT_W'(1);
      end

      out_valid_d = (state_d == ST_SHIFT);
      out_last_d  = (state_d == ST_SHIFT) && (cnt_d == CNT_W'(1));
      busy_d      = (state_d == ST_SHIFT) || pend_full_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         cnt_q        <= '0;
         pend_q       <= '0;
         pend_lanes_q <= '0;
         pend_full_q  <= 1'b0;
         data_out_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         pend_q       <= pend_d;
         pend_lanes_q <= pend_lanes_d;
         pend_full_q  <= pend_full_d;
         data_out_q   <= data_out_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         busy_q       <= busy_d;
      end
   end

endmodule

// File: tb/tb_serializer_nbyte.sv
// Scoreboard bench for serializer_nbyte: accepted words are expanded into expected lanes,
// a monitor compares every presented lane and the handshake/occupancy outputs.
module tb_serializer_nbyte;

   localparam int unsigned OUT_W     = 8;
   localparam int unsigned MAX_LANES = 4;
   localparam int unsigned IN_W      = OUT_W * MAX_LANES;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              enb = 1'b0;
   logic [IN_W-1:0]   dataIn = '0;
   logic [1:0]        dataS = '0;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic              in_ready;
   logic [OUT_W-1:0]  dataOut;
   logic              out_valid;
   logic              out_last;
   logic              busy;

   typedef struct packed {
      logic [OUT_W-1:0] d;
      logic             last;
   } lane_t;

   lane_t q[$];
   int    errors = 0;
   int    checks = 0;
   bit    rand_mode = 1'b0;

   serializer_nbyte #(.OUT_W(OUT_W), .MAX_LANES(MAX_LANES)) dut (
      .clk(clk), .rst(rst), .enb(enb),
      .dataIn(dataIn), .dataS(dataS), .in_valid(in_valid), .in_ready(in_ready),
      .dataOut(dataOut), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected lane sequence of one word, straight from the size/ordering rules.
   task automatic push_word(input logic [IN_W-1:0] w, input logic [1:0] s);
      int    l;
      lane_t ln;
      l = 1 << s;
      if (l > int'(MAX_LANES)) l = int'(MAX_LANES);
      for (int i = l - 1; i >= 0; i--) begin
         ln.d    = OUT_W'(w >> (i * OUT_W));
         ln.last = (i == 0);
         q.push_back(ln);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (rand_mode) begin
         out_ready = ($urandom_range(0, 3) != 0);
         enb       = ($urandom_range(0, 7) != 0);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_word(input logic [IN_W-1:0] w, input logic [1:0] s);
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      dataIn = w;
      dataS = s;
      in_valid = 1'b1;
      while (!acc) begin
         #3;
         acc = in_ready && enb;
         tick();
         n++;
         if (!acc && n > 200) begin
            chk("send_timeout", 64'(n), 64'd0);
            break;
         end
      end
      in_valid = 1'b0;
      dataIn = $urandom;
      dataS = 2'($urandom_range(0, 3));
   endtask

   task automatic drain();
      int n;
      n = 0;
      forever begin
         #3;
         if (!busy) break;
         tick();
         n++;
         if (n > 300) begin
            chk("drain_timeout", 64'(busy), 64'd0);
            break;
         end
      end
      @(negedge clk);
   endtask

   // Monitor: occupancy, handshake and lane checks every cycle, away from the edge.
   initial begin
      logic [OUT_W-1:0] prev_d;
      logic             prev_last;
      bit               prev_hold;
      int               nwords;
      prev_hold = 1'b0;
      prev_d = '0;
      prev_last = 1'b0;
      forever begin
         @(negedge clk);
         #3;
         if (rst) begin
            q.delete();
            prev_hold = 1'b0;
         end else begin
            nwords = 0;
            foreach (q[i]) if (q[i].last) nwords++;
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("busy", 64'(busy), 64'(q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(enb && nwords < 2));
            if (q.size() != 0) begin
               chk("dataOut", 64'(dataOut), 64'(q[0].d));
               chk("out_last", 64'(out_last), 64'(q[0].last));
            end
            if (prev_hold) begin
               chk("hold_data", 64'(dataOut), 64'(prev_d));
               chk("hold_last", 64'(out_last), 64'(prev_last));
            end
            prev_hold = out_valid && !(enb && out_ready);
            prev_d    = dataOut;
            prev_last = out_last;
            if (enb && in_valid && in_ready) push_word(dataIn, dataS);
            if (enb && out_valid && out_ready && q.size() != 0) void'(q.pop_front());
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("rst_dataOut", 64'(dataOut), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      enb = 1'b1;
      out_ready = 1'b1;

      // Byte mode back-to-back, junk in the ignored upper bits.
      send_word(32'habcdefff, 2'd0);
      send_word(32'h12345600, 2'd0);
      send_word(32'h000000f0, 2'd0);
      send_word(32'hffffff0f, 2'd0);
      drain();

      // 16-bit words with upper bits set.
      send_word(32'hffffad43, 2'd1);
      send_word(32'hffff543f, 2'd1);
      drain();

      // 32-bit with a 3-cycle stall while a second word fills the pending slot.
      send_word(32'h95fdad43, 2'd2);
      out_ready = 1'b0;
      dataIn = 32'h94d5543f;
      dataS = 2'd2;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #3;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_95", 64'(dataOut), 64'h95);
      tick();
      tick();
      out_ready = 1'b1;
      drain();

      // Size code above MAX_LANES clamps.
      send_word(32'h0378fdae, 2'd3);
      drain();

      // Enable low mid-word freezes output and blocks accepts.
      send_word(32'h95fdad43, 2'd2);
      tick();
      enb = 1'b0;
      dataIn = 32'h11223344;
      dataS = 2'd2;
      in_valid = 1'b1;
      tick();
      tick();
      #3;
      chk("enb_hold_fd", 64'(dataOut), 64'hfd);
      chk("enb_in_ready", 64'(in_ready), 64'd0);
      tick();
      in_valid = 1'b0;
      enb = 1'b1;
      drain();

      // Reset mid-word with the pending slot full.
      send_word(32'ha1b2c3d4, 2'd2);
      send_word(32'he5f60718, 2'd2);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_dataOut", 64'(dataOut), 64'd0);
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_out_last", 64'(out_last), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      send_word(32'h00007d5a, 2'd1);
      drain();

      // Randomised traffic with random backpressure and enable.
      rand_mode = 1'b1;
      for (int i = 0; i < 300; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         send_word($urandom, 2'($urandom_range(0, 3)));
      end
      rand_mode = 1'b0;
      enb = 1'b1;
      out_ready = 1'b1;
      drain();
      #3;
      chk("final_busy", 64'(busy), 64'd0);
      chk("final_queue", 64'(q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
